barrett_reduce_pipe: RTL

Multi-lane, fully pipelined Barrett reduction unit for Kyber coefficient arithmetic (q = 3329). It accepts LANES signed coefficients per beat and returns each reduced to the centered range [-(Q-1)/2, (Q-1)/2], or optionally to [0, Q-1]. It sits after the NTT butterfly and pointwise-multiply datapaths. It uses a valid/ready handshake with full backpressure and a pass-through tag, so it can be dropped between streaming stages.

---
 rtl/barrett_reduce_pipe_if.sv | 16 +
 rtl/barrett_reduce_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/barrett_reduce_pipe_if.sv
// Streaming beat bundle for barrett_reduce_pipe: valid/ready handshake,
// LANES packed signed coefficients and a sideband tag.
// The master drives valid/data/tag; the slave answers with ready.
interface barrett_reduce_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int TAG_W = 4
);
    logic                   valid;
    logic                   ready;
    logic [LANES*WIDTH-1:0] data;
    logic [TAG_W-1:0]       tag;

    modport master (output valid, output data, output tag, input ready);
    modport slave  (input valid, input data, input tag, output ready);
endinterface

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: multi-lane pipelined Barrett reduction for Kyber
// (q = 3329). Each lane computes t = (V*a + 2^(SHIFT-1)) >>> SHIFT and
// r = a - t*Q, giving the centered representative of a mod Q.
// Optional macro KYBER_BARRETT_CANON_EN adds a fourth stage that maps the
// result to [0, Q-1].
// One global advance enable stalls every stage together whenever the
// output beat is held by downstream, so ready never depends on in_valid.
module barrett_reduce_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int Q     = 3329,
    parameter int V     = 20159,
    parameter int SHIFT = 26,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    barrett_reduce_pipe_if.slave  inBus_i,
    barrett_reduce_pipe_if.master outBus_o
);

    localparam int DW = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0] coef_t;
    typedef logic signed [DW-1:0]    wide_t;

    localparam wide_t V_W   = wide_t'(V);
    localparam wide_t Q_W   = wide_t'(Q);
    localparam wide_t RND_W = wide_t'(1) <<< (SHIFT - 1);
`ifdef KYBER_BARRETT_CANON_EN
    localparam coef_t Q_C   = coef_t'(Q);
`endif

    logic adv;
    logic lastValid;

    // Stage 1: rounded product V*a and the original coefficient
    logic             s1Valid_q;
    logic [TAG_W-1:0] s1Tag_q;
    wide_t            s1Prod_d [LANES];
    wide_t            s1Prod_q [LANES];
    coef_t            s1A_q    [LANES];

    // Stage 2: quotient estimate times Q and the original coefficient
    logic             s2Valid_q;
    logic [TAG_W-1:0] s2Tag_q;
    wide_t            s2Tq_d   [LANES];
    wide_t            s2Tq_q   [LANES];
    coef_t            s2A_q    [LANES];

    // Stage 3: reduced coefficient
    logic             s3Valid_q;
    logic [TAG_W-1:0] s3Tag_q;
    coef_t            s3R_d    [LANES];
    coef_t            s3R_q    [LANES];

`ifdef KYBER_BARRETT_CANON_EN
    // Stage 4: canonical coefficient in [0, Q-1]
    logic             s4Valid_q;
    logic [TAG_W-1:0] s4Tag_q;
    coef_t            s4R_d    [LANES];
    coef_t            s4R_q    [LANES];
`endif

    coef_t aIn    [LANES];
    wide_t tWide  [LANES];
    coef_t tTrunc [LANES];
    wide_t rWide  [LANES];

    // Whole pipe moves only when the output slot is empty or being taken
    assign adv           = !lastValid || outBus_o.ready;
    assign inBus_i.ready = adv;

    // Per-lane Barrett datapath between stage registers; t and r are cut to WIDTH
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            aIn[i]      = coef_t'(inBus_i.data[i*WIDTH +: WIDTH]);
            s1Prod_d[i] = V_W * wide_t'(aIn[i]) + RND_W;
            tWide[i]    = s1Prod_q[i] >>> SHIFT;
            tTrunc[i]   = tWide[i][WIDTH-1:0];
            s2Tq_d[i]   = wide_t'(tTrunc[i]) * Q_W;
            rWide[i]    = wide_t'(s2A_q[i]) - s2Tq_q[i];
            s3R_d[i]    = rWide[i][WIDTH-1:0];
`ifdef KYBER_BARRETT_CANON_EN
            s4R_d[i]    = (s3R_q[i] < 0) ? s3R_q[i] + Q_C : s3R_q[i];
`endif
        end
    end

    // Stage 1 capture of the incoming beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Tag_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1Prod_q[i] <= '0;
                s1A_q[i]    <= '0;
            end
        end else if (adv) begin
            s1Valid_q <= inBus_i.valid;
            s1Tag_q   <= inBus_i.tag;
            for (int i = 0; i < LANES; i++) begin
                s1Prod_q[i] <= s1Prod_d[i];
                s1A_q[i]    <= aIn[i];
            end
        end
    end

    // Stage 2 capture of t*Q
    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2Tag_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s2Tq_q[i] <= '0;
                s2A_q[i]  <= '0;
            end
        end else if (adv) begin
            s2Valid_q <= s1Valid_q;
            s2Tag_q   <= s1Tag_q;
            for (int i = 0; i < LANES; i++) begin
                s2Tq_q[i] <= s2Tq_d[i];
                s2A_q[i]  <= s1A_q[i];
            end
        end
    end

    // Stage 3 capture of the centered remainder
    always_ff @(posedge clk) begin
        if (rst) begin
            s3Valid_q <= 1'b0;
            s3Tag_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s3R_q[i] <= '0;
            end
        end else if (adv) begin
            s3Valid_q <= s2Valid_q;
            s3Tag_q   <= s2Tag_q;
            for (int i = 0; i < LANES; i++) begin
                s3R_q[i] <= s3R_d[i];
            end
        end
    end

`ifdef KYBER_BARRETT_CANON_EN
    // Stage 4 capture of the canonical remainder
    always_ff @(posedge clk) begin
        if (rst) begin
            s4Valid_q <= 1'b0;
            s4Tag_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                s4R_q[i] <= '0;
            end
        end else if (adv) begin
            s4Valid_q <= s3Valid_q;
            s4Tag_q   <= s3Tag_q;
            for (int i = 0; i < LANES; i++) begin
                s4R_q[i] <= s4R_d[i];
            end
        end
    end

    assign lastValid      = s4Valid_q;
    assign outBus_o.tag   = s4Tag_q;

    // Pack the last stage lanes onto the output bus
    always_comb begin
        outBus_o.data = '0;
        for (int i = 0; i < LANES; i++) begin
            outBus_o.data[i*WIDTH +: WIDTH] = s4R_q[i];
        end
    end
`else
    assign lastValid      = s3Valid_q;
    assign outBus_o.tag   = s3Tag_q;

    // Pack the last stage lanes onto the output bus
    always_comb begin
        outBus_o.data = '0;
        for (int i = 0; i < LANES; i++) begin
            outBus_o.data[i*WIDTH +: WIDTH] = s3R_q[i];
        end
    end
`endif

    assign outBus_o.valid = lastValid;

endmodule
